// File: rtl/logical_tile_memory_mode_mem_cfg_dp.sv
// Simple dual-port config memory with write-first bypass and a
// sequential clear sweep; optional second read pipeline stage.
module logical_tile_memory_mode_mem_cfg_dp #(
  parameter int AW      = 10,
  parameter int DW      = 8,
  parameter int OUT_REG = 0
) (
  input  logic          mem_cfg_dp_clk,
  input  logic          mem_cfg_dp_rst_n,
  input  logic [AW-1:0] mem_cfg_dp_waddr,
  input  logic [AW-1:0] mem_cfg_dp_raddr,
  input  logic [DW-1:0] mem_cfg_dp_data_in,
  input  logic          mem_cfg_dp_wen,
  input  logic          mem_cfg_dp_ren,
  input  logic          mem_cfg_dp_clr,
  output logic [DW-1:0] mem_cfg_dp_data_out,
  output logic          mem_cfg_dp_rvalid,
  output logic          mem_cfg_dp_busy
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t        state;
  logic [AW-1:0] ptr;
  logic          busy_q;
  logic          idle;

  logic [DW-1:0] mem [DEPTH];

  logic          we;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;

  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_fire;

  assign idle    = (state == IDLE);
  assign rd_fire = idle && mem_cfg_dp_ren;

  // The sweep owns the single write port while clearing.
  always_comb begin
    we = mem_cfg_dp_wen;
    wa = mem_cfg_dp_waddr;
    wd = mem_cfg_dp_data_in;
    if (!idle) begin
      we = 1'b1;
      wa = ptr;
      wd = '0;
    end
  end

  always_ff @(posedge mem_cfg_dp_clk) begin
    if (we) begin
      mem[wa] <= wd;
    end
  end

  always_ff @(posedge mem_cfg_dp_clk or negedge mem_cfg_dp_rst_n) begin
    if (!mem_cfg_dp_rst_n) begin
      state  <= IDLE;
      ptr    <= '0;
      busy_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (mem_cfg_dp_clr) begin
            state  <= CLEAR;
            ptr    <= '0;
            busy_q <= 1'b1;
          end
        end
        CLEAR: begin
          ptr <= ptr + 1'b1;
          if (ptr == '1) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge mem_cfg_dp_clk or negedge mem_cfg_dp_rst_n) begin
    if (!mem_cfg_dp_rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_fire;
      if (rd_fire) begin
        if (mem_cfg_dp_wen &&
            (mem_cfg_dp_waddr == mem_cfg_dp_raddr)) begin
          rd_data <= mem_cfg_dp_data_in;
        end else begin
          rd_data <= mem[mem_cfg_dp_raddr];
        end
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DW-1:0] out_q;
      logic          out_v;

      always_ff @(posedge mem_cfg_dp_clk or negedge mem_cfg_dp_rst_n) begin
        if (!mem_cfg_dp_rst_n) begin
          out_q <= '0;
          out_v <= 1'b0;
        end else begin
          out_v <= rd_valid;
          if (rd_valid) begin
            out_q <= rd_data;
          end
        end
      end

      assign mem_cfg_dp_data_out = out_q;
      assign mem_cfg_dp_rvalid   = out_v;
    end else begin : g_no_out_reg
      assign mem_cfg_dp_data_out = rd_data;
      assign mem_cfg_dp_rvalid   = rd_valid;
    end
  endgenerate

  assign mem_cfg_dp_busy = busy_q;

endmodule

// File: tb/tb_logical_tile_memory_mode_mem_cfg_dp.sv
// Directed bench: default, OUT_REG=1 (same stimulus) and AW=4/DW=32.
// Inputs change 1ns after posedge; outputs sampled at the same point.
module tb_logical_tile_memory_mode_mem_cfg_dp;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [9:0] waddr = '0;
  logic [9:0] raddr = '0;
  logic [7:0] data_in = '0;
  logic       wen = 1'b0;
  logic       ren = 1'b0;
  logic       clr = 1'b0;

  logic [7:0] d0, d1;
  logic       v0, v1, b0, b1;

  logic [3:0]  s_waddr = '0;
  logic [3:0]  s_raddr = '0;
  logic [31:0] s_din = '0;
  logic        s_wen = 1'b0;
  logic        s_ren = 1'b0;
  logic        s_clr = 1'b0;
  logic [31:0] s_dout;
  logic        s_rv, s_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logical_tile_memory_mode_mem_cfg_dp u_dut0 (
    .mem_cfg_dp_clk(clk), .mem_cfg_dp_rst_n(rst_n),
    .mem_cfg_dp_waddr(waddr), .mem_cfg_dp_raddr(raddr),
    .mem_cfg_dp_data_in(data_in), .mem_cfg_dp_wen(wen),
    .mem_cfg_dp_ren(ren), .mem_cfg_dp_clr(clr),
    .mem_cfg_dp_data_out(d0), .mem_cfg_dp_rvalid(v0),
    .mem_cfg_dp_busy(b0)
  );

  logical_tile_memory_mode_mem_cfg_dp #(.OUT_REG(1)) u_dut1 (
    .mem_cfg_dp_clk(clk), .mem_cfg_dp_rst_n(rst_n),
    .mem_cfg_dp_waddr(waddr), .mem_cfg_dp_raddr(raddr),
    .mem_cfg_dp_data_in(data_in), .mem_cfg_dp_wen(wen),
    .mem_cfg_dp_ren(ren), .mem_cfg_dp_clr(clr),
    .mem_cfg_dp_data_out(d1), .mem_cfg_dp_rvalid(v1),
    .mem_cfg_dp_busy(b1)
  );

  logical_tile_memory_mode_mem_cfg_dp #(.AW(4), .DW(32)) u_dut_s (
    .mem_cfg_dp_clk(clk), .mem_cfg_dp_rst_n(rst_n),
    .mem_cfg_dp_waddr(s_waddr), .mem_cfg_dp_raddr(s_raddr),
    .mem_cfg_dp_data_in(s_din), .mem_cfg_dp_wen(s_wen),
    .mem_cfg_dp_ren(s_ren), .mem_cfg_dp_clr(s_clr),
    .mem_cfg_dp_data_out(s_dout), .mem_cfg_dp_rvalid(s_rv),
    .mem_cfg_dp_busy(s_busy)
  );

  function automatic logic [7:0] fill(int i);
    return 8'((i % 255) + 1);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    tick;
    tick;
    checks++;
    if ({d0, v0, b0} !== 10'h0) begin
      errors++;
      $display("FAIL reset_dut0 got d=%h v=%b b=%b want 0", d0, v0, b0);
    end
    checks++;
    if ({d1, v1, b1} !== 10'h0) begin
      errors++;
      $display("FAIL reset_dut1 got d=%h v=%b b=%b want 0", d1, v1, b1);
    end
    checks++;
    if ({s_dout, s_rv, s_busy} !== 34'h0) begin
      errors++;
      $display("FAIL reset_small got d=%h v=%b b=%b want 0",
               s_dout, s_rv, s_busy);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_write_read;
    wen = 1'b1; waddr = 10'h3FF; data_in = 8'hA5;
    tick;
    wen = 1'b0; ren = 1'b1; raddr = 10'h3FF;
    tick;
    checks++;
    if (v0 !== 1'b1 || d0 !== 8'hA5) begin
      errors++;
      $display("FAIL wr_rd_lat1 got v=%b d=%h want v=1 d=a5", v0, d0);
    end
    checks++;
    if (v1 !== 1'b0) begin
      errors++;
      $display("FAIL wr_rd_oreg_early got v=%b want 0", v1);
    end
    ren = 1'b0;
    tick;
    checks++;
    if (v0 !== 1'b0 || d0 !== 8'hA5) begin
      errors++;
      $display("FAIL wr_rd_hold got v=%b d=%h want v=0 d=a5", v0, d0);
    end
    checks++;
    if (v1 !== 1'b1 || d1 !== 8'hA5) begin
      errors++;
      $display("FAIL wr_rd_lat2 got v=%b d=%h want v=1 d=a5", v1, d1);
    end
    tick;
    checks++;
    if (v1 !== 1'b0 || d1 !== 8'hA5) begin
      errors++;
      $display("FAIL wr_rd_oreg_hold got v=%b d=%h want v=0 d=a5", v1, d1);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp [3];
    exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      wen = 1'b1; waddr = 10'(i + 1); data_in = exp[i];
      tick;
    end
    wen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ren = (i < 3);
      raddr = 10'(i + 1);
      tick;
      checks++;
      if (i < 3) begin
        if (v0 !== 1'b1 || d0 !== exp[i]) begin
          errors++;
          $display("FAIL b2b_dut0[%0d] got v=%b d=%h want v=1 d=%h",
                   i, v0, d0, exp[i]);
        end
      end else if (v0 !== 1'b0 || d0 !== 8'h33) begin
        errors++;
        $display("FAIL b2b_dut0_idle[%0d] got v=%b d=%h want v=0 d=33",
                 i, v0, d0);
      end
      checks++;
      if (i >= 1 && i < 4) begin
        if (v1 !== 1'b1 || d1 !== exp[i-1]) begin
          errors++;
          $display("FAIL b2b_dut1[%0d] got v=%b d=%h want v=1 d=%h",
                   i, v1, d1, exp[i-1]);
        end
      end else if (v1 !== 1'b0) begin
        errors++;
        $display("FAIL b2b_dut1_idle[%0d] got v=%b want v=0", i, v1);
      end
    end
    ren = 1'b0;
  endtask

  task automatic test_collision;
    wen = 1'b1; waddr = 10'h010; data_in = 8'h00;
    tick;
    ren = 1'b1; raddr = 10'h010; data_in = 8'h5A;
    tick;
    checks++;
    if (v0 !== 1'b1 || d0 !== 8'h5A) begin
      errors++;
      $display("FAIL collision got v=%b d=%h want v=1 d=5a", v0, d0);
    end
    waddr = 10'h020; data_in = 8'h77; raddr = 10'h3FF;
    tick;
    checks++;
    if (v1 !== 1'b1 || d1 !== 8'h5A) begin
      errors++;
      $display("FAIL collision_oreg got v=%b d=%h want v=1 d=5a", v1, d1);
    end
    checks++;
    if (v0 !== 1'b1 || d0 !== 8'hA5) begin
      errors++;
      $display("FAIL indep_read got v=%b d=%h want v=1 d=a5", v0, d0);
    end
    wen = 1'b0; raddr = 10'h020;
    tick;
    checks++;
    if (v0 !== 1'b1 || d0 !== 8'h77) begin
      errors++;
      $display("FAIL indep_write got v=%b d=%h want v=1 d=77", v0, d0);
    end
    ren = 1'b0;
    tick;
  endtask

  task automatic test_clear;
    logic [7:0] hold;
    logic [9:0] addrs [4];
    int cnt;
    int bad;
    addrs[0] = 10'h000; addrs[1] = 10'h200;
    addrs[2] = 10'h3FF; addrs[3] = 10'h005;
    for (int i = 0; i < 1024; i++) begin
      wen = 1'b1; waddr = 10'(i); data_in = fill(i);
      tick;
    end
    hold = fill(512);
    clr = 1'b1; waddr = 10'h005; data_in = 8'hEE;
    ren = 1'b1; raddr = 10'h200;
    tick;
    checks++;
    if (v0 !== 1'b1 || d0 !== hold || b0 !== 1'b1) begin
      errors++;
      $display("FAIL clr_edge_read got v=%b d=%h b=%b want v=1 d=%h b=1",
               v0, d0, b0, hold);
    end
    data_in = 8'hFF;
    tick;
    checks++;
    if (v0 !== 1'b0 || v1 !== 1'b1 || d1 !== hold || b0 !== 1'b1) begin
      errors++;
      $display("FAIL clr_drain got v0=%b v1=%b d1=%h b=%b want 0 1 %h 1",
               v0, v1, d1, b0, hold);
    end
    cnt = 2;
    bad = 0;
    while (cnt < 2000) begin
      raddr = 10'(cnt);
      waddr = 10'(cnt);
      tick;
      if (!b0) break;
      cnt++;
      if (v0 || v1 || d0 !== hold || d1 !== hold) bad++;
    end
    wen = 1'b0; ren = 1'b0; clr = 1'b0;
    checks++;
    if (cnt != 1024) begin
      errors++;
      $display("FAIL clr_busy_len got %0d want 1024", cnt);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL clr_ignore_ren got %0d bad cycles want 0", bad);
    end
    for (int i = 0; i < 4; i++) begin
      raddr = addrs[i]; ren = 1'b1;
      tick;
      checks++;
      if (v0 !== 1'b1 || d0 !== 8'h00) begin
        errors++;
        $display("FAIL clr_read0[%h] got v=%b d=%h want v=1 d=00",
                 addrs[i], v0, d0);
      end
      ren = 1'b0;
      tick;
      checks++;
      if (v1 !== 1'b1 || d1 !== 8'h00) begin
        errors++;
        $display("FAIL clr_read1[%h] got v=%b d=%h want v=1 d=00",
                 addrs[i], v1, d1);
      end
    end
  endtask

  task automatic test_reset_inflight;
    raddr = 10'h3FF; ren = 1'b1;
    tick;
    ren = 1'b0;
    rst_n = 1'b0;
    #3 rst_n = 1'b1;
    tick;
    checks++;
    if (v0 !== 1'b0 || v1 !== 1'b0) begin
      errors++;
      $display("FAIL rst_inflight got v0=%b v1=%b want 0 0", v0, v1);
    end
    tick;
    checks++;
    if (v1 !== 1'b0) begin
      errors++;
      $display("FAIL rst_inflight_late got v1=%b want 0", v1);
    end
  endtask

  task automatic test_reset_mid_clear;
    int cnt;
    wen = 1'b1; waddr = 10'h007; data_in = 8'h3C;
    tick;
    wen = 1'b0; ren = 1'b1; raddr = 10'h007;
    tick;
    ren = 1'b0;
    tick;
    clr = 1'b1;
    tick;
    clr = 1'b0;
    repeat (99) tick;
    checks++;
    if (b0 !== 1'b1 || d0 !== 8'h3C) begin
      errors++;
      $display("FAIL midclr_pre got b=%b d=%h want b=1 d=3c", b0, d0);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({d0, v0, b0} !== 10'h0 || {d1, v1, b1} !== 10'h0) begin
      errors++;
      $display("FAIL midclr_rst got d0=%h v0=%b b0=%b d1=%h v1=%b b1=%b",
               d0, v0, b0, d1, v1, b1);
    end
    #2 rst_n = 1'b1;
    tick;
    checks++;
    if (b0 !== 1'b0 || v0 !== 1'b0 || d0 !== 8'h00) begin
      errors++;
      $display("FAIL midclr_post got b=%b v=%b d=%h want 0 0 00",
               b0, v0, d0);
    end
    clr = 1'b1;
    tick;
    clr = 1'b0;
    cnt = 1;
    while (cnt < 2000) begin
      tick;
      if (!b0) break;
      cnt++;
    end
    checks++;
    if (cnt != 1024) begin
      errors++;
      $display("FAIL midclr_resweep got %0d want 1024", cnt);
    end
    raddr = 10'h3FF; ren = 1'b1;
    tick;
    ren = 1'b0;
    checks++;
    if (v0 !== 1'b1 || d0 !== 8'h00) begin
      errors++;
      $display("FAIL midclr_read got v=%b d=%h want v=1 d=00", v0, d0);
    end
  endtask

  task automatic test_small;
    int cnt;
    s_wen = 1'b1; s_waddr = 4'hF; s_din = 32'hDEADBEEF;
    tick;
    s_wen = 1'b0; s_ren = 1'b1; s_raddr = 4'hF;
    tick;
    s_ren = 1'b0;
    checks++;
    if (s_rv !== 1'b1 || s_dout !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL small_rd got v=%b d=%h want v=1 d=deadbeef",
               s_rv, s_dout);
    end
    s_clr = 1'b1;
    tick;
    s_clr = 1'b0;
    cnt = 1;
    while (cnt < 200) begin
      tick;
      if (!s_busy) break;
      cnt++;
    end
    checks++;
    if (cnt != 16) begin
      errors++;
      $display("FAIL small_busy_len got %0d want 16", cnt);
    end
    s_ren = 1'b1; s_raddr = 4'hF;
    tick;
    s_ren = 1'b0;
    checks++;
    if (s_rv !== 1'b1 || s_dout !== 32'h0) begin
      errors++;
      $display("FAIL small_clr_rd got v=%b d=%h want v=1 d=0", s_rv, s_dout);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_collision();
    test_clear();
    test_reset_inflight();
    test_reset_mid_clear();
    test_small();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
